uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte sources, each backed by its own FIFO. It sits between the per-source FIFOs and the `uart` TX path. It pops one byte from the granted FIFO, presents it to the transmitter with a one-cycle start pulse, and waits for the transmitter's done pulse before scheduling again. A burst limit lets one source send up to `MAX_BURST` consecutive bytes before ownership rotates.

---
 rtl/uart_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART transmitter
// between N_REQ FIFO-backed byte sources, with a per-owner burst limit.
//
// Ports:
//   clk              system clock, rising edge
//   rst_in           asynchronous active-high reset
//   req_empty_in     per-requester FIFO empty flags
//   req_data_in      per-requester FIFO read data, requester i at [i*DATA_BITS +: DATA_BITS]
//   req_read_out     one-hot FIFO read strobe, one cycle per byte
//   tx_data_out      byte presented to the UART transmitter
//   tx_data_rdy_out  one-cycle start pulse to the UART transmitter
//   tx_done_in       one-cycle frame-complete pulse from the UART transmitter
//   grant_out        one-hot current owner, zero while idle
//   busy_out         high whenever a byte is in flight
module uart_tx_scheduler #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic [N_REQ-1:0]             req_empty_in,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data_in,
    output logic [N_REQ-1:0]             req_read_out,
    output logic [DATA_BITS-1:0]         tx_data_out,
    output logic                         tx_data_rdy_out,
    input  logic                         tx_done_in,
    output logic [N_REQ-1:0]             grant_out,
    output logic                         busy_out
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          g_q, g_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          sel;
    logic                   found;
    logic [IW-1:0]          g_next_wrap;
    logic                   burst_last;
    logic [DATA_BITS-1:0]   tx_data_d;
    logic [N_REQ-1:0]       g_onehot_d;
    logic [N_REQ-1:0]       read_d;
    logic [N_REQ-1:0]       grant_d;
    logic                   rdy_d;
    logic                   busy_d;

    // Single-cycle search for the first non-empty requester at or above ptr.
    // Iterating downward lets the smallest wrapped offset win.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        sel   = ptr_q;
        found = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = 32'(ptr_q) + 32'(i);
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!req_empty_in[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    // Owner index plus one with explicit wrap for non-power-of-2 N_REQ.
    always_comb begin
        g_next_wrap = g_q + IW'(1);
        if (32'(g_q) + 32'd1 == N_REQ) begin
            g_next_wrap = '0;
        end
        burst_last = (32'(cnt_q) + 32'd1 == MAX_BURST);
    end

    // Next-state, bookkeeping and next-output logic.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_out;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_READ;
                    g_d     = sel;
                    // A new owner starts a fresh burst.
                    if (sel != g_q) begin
                        cnt_d = '0;
                        ptr_d = sel;
                    end
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                state_d   = S_START;
                tx_data_d = req_data_in[32'(g_q)*DATA_BITS +: DATA_BITS];
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_in) begin
                    state_d = S_IDLE;
                    if (burst_last) begin
                        ptr_d = g_next_wrap;
                        cnt_d = '0;
                    end else begin
                        ptr_d = g_q;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        g_onehot_d       = '0;
        g_onehot_d[g_d]  = 1'b1;
        read_d  = (state_d == S_READ)  ? g_onehot_d : '0;
        grant_d = (state_d != S_IDLE)  ? g_onehot_d : '0;
        rdy_d   = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    // State, bookkeeping and output registers; outputs track the state register.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= S_IDLE;
            g_q             <= '0;
            ptr_q           <= '0;
            cnt_q           <= '0;
            tx_data_out     <= '0;
            req_read_out    <= '0;
            grant_out       <= '0;
            tx_data_rdy_out <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            state_q         <= state_d;
            g_q             <= g_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            tx_data_out     <= tx_data_d;
            req_read_out    <= read_d;
            grant_out       <= grant_d;
            tx_data_rdy_out <= rdy_d;
            busy_out        <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (4 requesters / burst 4 and
// 3 requesters / burst 1) share one FIFO + UART harness selected by use_b.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst;
    logic        tx_done;
    logic        use_b;
    logic [31:0] data_bus;
    logic [3:0]  empty_a;
    logic [2:0]  empty_b;

    logic [3:0]  rd_a, grant_a;
    logic [7:0]  txd_a;
    logic        rdy_a, busy_a;
    logic [2:0]  rd_b, grant_b;
    logic [7:0]  txd_b;
    logic        rdy_b, busy_b;

    logic [3:0]  rd, grant;
    logic [7:0]  txd;
    logic        rdy, busy;

    uart_tx_scheduler #(.N_REQ(4), .DATA_BITS(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_in(rst), .req_empty_in(empty_a), .req_data_in(data_bus),
        .req_read_out(rd_a), .tx_data_out(txd_a), .tx_data_rdy_out(rdy_a),
        .tx_done_in(tx_done), .grant_out(grant_a), .busy_out(busy_a)
    );

    uart_tx_scheduler #(.N_REQ(3), .DATA_BITS(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_in(rst), .req_empty_in(empty_b), .req_data_in(data_bus[23:0]),
        .req_read_out(rd_b), .tx_data_out(txd_b), .tx_data_rdy_out(rdy_b),
        .tx_done_in(tx_done), .grant_out(grant_b), .busy_out(busy_b)
    );

    assign rd    = use_b ? {1'b0, rd_b}    : rd_a;
    assign grant = use_b ? {1'b0, grant_b} : grant_a;
    assign txd   = use_b ? txd_b  : txd_a;
    assign rdy   = use_b ? rdy_b  : rdy_a;
    assign busy  = use_b ? busy_b : busy_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] fq[4][$];     // FIFO contents as seen by the DUT
    logic [7:0] exp_q[4][$];  // expected byte order per requester

    int m_ptr[2];
    int m_cnt[2];
    int m_prev[2];

    typedef struct packed {
        logic        use_b;
        logic [15:0] cnt;     // bytes per FIFO, FIFO0 in the leftmost nibble
        logic [3:0]  n_exp;
        logic [31:0] order;   // expected grant order, first grant leftmost
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        logic [3:0] e;
        for (int r = 0; r < 4; r++) e[r] = (fq[r].size() == 0);
        empty_a = use_b ? 4'hF : e;
        empty_b = use_b ? e[2:0] : 3'h7;
    endtask

    task automatic load_byte(input int r, input logic [7:0] b);
        fq[r].push_back(b);
        exp_q[r].push_back(b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
        end
    endtask

    task automatic assert_reset_now();
        rst = 1'b1;
        tx_done = 1'b0;
        #1;
        chk("rst_read", 32'(rd), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_txdata", 32'(txd), 0);
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        assert_reset_now();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_read", 32'(rd), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_grant", 32'(grant), 0);
        end
    endtask

    // One byte from requester er: strobe, latch, start pulse, wait, done.
    task automatic check_byte(input int er, input bit spurious, input bit hold);
        int w;
        logic [7:0] eb;
        logic [31:0] oh;
        oh = 32'd1 << er;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (rd == '0 && w < 40);
        chk("idle_to_read", 32'(w), 1);
        if (rd == '0) return;
        chk("read_strobe", 32'(rd), oh);
        chk("grant_read", 32'(grant), oh);
        chk("busy_read", 32'(busy), 1);
        for (int r = 0; r < 4; r++) begin
            if (rd[r] && fq[r].size() > 0) data_bus[r*8 +: 8] = fq[r].pop_front();
        end
        upd_empty();
        eb = 8'h00;
        if (exp_q[er].size() > 0) eb = exp_q[er].pop_front();
        if (spurious) tx_done = 1'b1;
        @(negedge clk);
        chk("read_one_cycle", 32'(rd), 0);
        chk("rdy_latch", 32'(rdy), 0);
        @(negedge clk);
        chk("start_pulse", 32'(rdy), 1);
        chk("tx_data", 32'(txd), 32'(eb));
        chk("grant_start", 32'(grant), oh);
        @(negedge clk);
        tx_done = 1'b0;
        chk("start_one_cycle", 32'(rdy), 0);
        chk("busy_wait", 32'(busy), 1);
        if (hold) return;
        repeat (spurious ? 3 : int'($urandom_range(0, 3))) @(negedge clk);
        chk("wait_holds", {27'd0, busy, rd}, 32'h10);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("idle_after_done", 32'(busy), 0);
        chk("grant_idle", 32'(grant), 0);
    endtask

    initial begin
        rst      = 1'b1;
        tx_done  = 1'b0;
        use_b    = 1'b0;
        data_bus = '0;
        upd_empty();
        model_reset();

        vecs[0] = '{1'b0, 16'h0100, 4'd1, 32'h0000_0001};  // single byte 0xA5 from FIFO1
        vecs[1] = '{1'b0, 16'h6020, 4'd8, 32'h0000_2200};  // burst of 4, then FIFO2, then FIFO0
        vecs[2] = '{1'b1, 16'h2220, 4'd6, 32'h0001_2012};  // burst 1 fairness over 3
        vecs[3] = '{1'b1, 16'h2020, 4'd4, 32'h0000_0202};  // wrap with 3 requesters
        vecs[4] = '{1'b0, 16'h1111, 4'd4, 32'h0000_0123};  // owner empties early
        vecs[5] = '{1'b0, 16'h0005, 4'd5, 32'h0003_3333};  // sole requester keeps winning
        vecs[6] = '{1'b0, 16'h5001, 4'd6, 32'h0000_0030};  // rotation to FIFO3 and back

        for (int v = 0; v < 7; v++) begin
            logic [15:0] cn;
            logic [31:0] ord;
            int n;
            cn  = vecs[v].cnt;
            ord = vecs[v].order;
            n   = int'(vecs[v].n_exp);
            do_reset();
            use_b = vecs[v].use_b;
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < int'(cn[(3-r)*4 +: 4]); k++) begin
                    load_byte(r, 8'(32'h94 + 32'h11 * r + 32'h2 * k));
                end
            end
            upd_empty();
            for (int i = 0; i < n; i++) begin
                check_byte(int'(ord[(n-1-i)*4 +: 4]), 1'b0, 1'b0);
            end
            check_idle(3);
        end

        // Done pulses during READ/LATCH/START must be ignored.
        do_reset();
        use_b = 1'b0;
        load_byte(2, 8'h3C);
        upd_empty();
        check_byte(2, 1'b1, 1'b0);
        check_idle(3);

        // Reset while waiting: popped byte is dropped, burst count restarts.
        do_reset();
        use_b = 1'b0;
        for (int k = 0; k < 4; k++) load_byte(0, 8'(8'h40 + k));
        load_byte(2, 8'h77);
        upd_empty();
        for (int k = 0; k < 3; k++) check_byte(0, 1'b0, 1'b0);
        check_byte(0, 1'b0, 1'b1);
        assert_reset_now();
        for (int k = 0; k < 4; k++) load_byte(0, 8'(8'h50 + k));
        upd_empty();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) check_byte(0, 1'b0, 1'b0);
        check_byte(2, 1'b0, 1'b0);
        check_idle(3);

        // Random FIFO fills checked against a byte-level round-robin model.
        do_reset();
        for (int rnd = 0; rnd < 12; rnd++) begin
            int b, nr, mb, w;
            int left[4];
            b  = rnd % 2;
            nr = (b == 1) ? 3 : 4;
            mb = (b == 1) ? 1 : 4;
            use_b = 1'(b);
            for (int r = 0; r < 4; r++) begin
                left[r] = (r < nr) ? int'($urandom_range(0, 4)) : 0;
                for (int k = 0; k < left[r]; k++) load_byte(r, 8'($urandom));
            end
            upd_empty();
            while (1) begin
                w = -1;
                for (int i = 0; i < nr; i++) begin
                    int c;
                    c = (m_ptr[b] + i) % nr;
                    if (w < 0 && left[c] > 0) w = c;
                end
                if (w < 0) break;
                if (w != m_prev[b]) m_cnt[b] = 0;
                check_byte(w, ($urandom_range(0, 3) == 0), 1'b0);
                left[w]--;
                if (m_cnt[b] + 1 == mb) begin
                    m_ptr[b] = (w + 1) % nr;
                    m_cnt[b] = 0;
                end else begin
                    m_ptr[b] = w;
                    m_cnt[b] = m_cnt[b] + 1;
                end
                m_prev[b] = w;
            end
            check_idle(2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
